// File: rtl/if_branch_prediction_bht_gshare.sv
// IF-stage direction predictor: table of saturating counters indexed by PC,
// optionally XORed with global history (gshare), trained by EX feedback.
module if_branch_prediction_bht_gshare #(
  parameter int unsigned INDEX_BITS   = 10,
  parameter int unsigned COUNTER_BITS = 2,
  parameter int unsigned HISTORY_BITS = 8,
  parameter bit          GSHARE       = 1'b1,
  parameter logic [2:0]  INIT_STATE   = 3'b010,
  parameter int unsigned ADDR_LSB     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             pc_jmp,
  output logic                    pc_prediction_take,
  output logic                    pc_prediction_strong,
  output logic [HISTORY_BITS-1:0] pc_prediction_ghr,
  input  logic                    pc_jmp_feedback,
  input  logic                    pc_jmp_take,
  input  logic [31:0]             pc_stash_base,
  input  logic [HISTORY_BITS-1:0] pc_stash_ghr,
  input  logic                    pc_ghr_clear
);

  localparam int unsigned DEPTH     = 32'd1 << INDEX_BITS;
  localparam int unsigned GHR_SHIFT = INDEX_BITS - HISTORY_BITS;
  localparam logic [COUNTER_BITS-1:0] CTR_INIT = COUNTER_BITS'(INIT_STATE);
  localparam logic [COUNTER_BITS-1:0] CTR_MAX  = '1;
  localparam logic [COUNTER_BITS-1:0] CTR_ONE  = COUNTER_BITS'(1);

  logic [COUNTER_BITS-1:0] bht [DEPTH];
  logic [HISTORY_BITS-1:0] ghr;

  logic [INDEX_BITS-1:0]   lookup_idx;
  logic [INDEX_BITS-1:0]   update_idx;
  logic [COUNTER_BITS-1:0] rd_ctr;
  logic [COUNTER_BITS-1:0] up_ctr;
  logic [COUNTER_BITS-1:0] nxt_ctr;

  // History sits in the upper HISTORY_BITS of the index.
  function automatic logic [INDEX_BITS-1:0] table_index(
    input logic [INDEX_BITS-1:0]   pidx,
    input logic [HISTORY_BITS-1:0] hist
  );
    if (GSHARE) begin
      return pidx ^ (INDEX_BITS'(hist) << GHR_SHIFT);
    end
    return pidx;
  endfunction

  // Lookup uses the live GHR; training uses the GHR stashed at prediction time.
  always_comb begin
    lookup_idx = table_index(pc_jmp[ADDR_LSB +: INDEX_BITS], ghr);
    update_idx = table_index(pc_stash_base[ADDR_LSB +: INDEX_BITS], pc_stash_ghr);
    rd_ctr     = bht[lookup_idx];
    up_ctr     = bht[update_idx];
    nxt_ctr    = up_ctr;
    if (pc_jmp_take) begin
      if (up_ctr != CTR_MAX) nxt_ctr = up_ctr + CTR_ONE;
    end else begin
      if (up_ctr != '0) nxt_ctr = up_ctr - CTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bht[INDEX_BITS'(i)] <= CTR_INIT;
      end
      ghr <= '0;
    end else begin
      if (pc_jmp_feedback) begin
        bht[update_idx] <= nxt_ctr;
      end
      // Clear wins over a same-cycle shift; the counter still trains.
      if (pc_ghr_clear) begin
        ghr <= '0;
      end else if (pc_jmp_feedback) begin
        ghr <= HISTORY_BITS'({ghr, pc_jmp_take});
      end
    end
  end

  assign pc_prediction_take   = rd_ctr[COUNTER_BITS-1];
  assign pc_prediction_strong = (rd_ctr == CTR_MAX) || (rd_ctr == '0);
  assign pc_prediction_ghr    = ghr;

  // PC bits outside the index slice are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_jmp, pc_stash_base};

endmodule

// File: tb/tb_if_branch_prediction_bht_gshare.sv
// Self-checking bench for if_branch_prediction_bht_gshare (default parameters,
// gshare mode) against an array-based reference model.
module tb_if_branch_prediction_bht_gshare;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_jmp;
  logic        pc_prediction_take;
  logic        pc_prediction_strong;
  logic [7:0]  pc_prediction_ghr;
  logic        pc_jmp_feedback;
  logic        pc_jmp_take;
  logic [31:0] pc_stash_base;
  logic [7:0]  pc_stash_ghr;
  logic        pc_ghr_clear;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  int m_ctr [DEPTH];
  int m_ghr;

  if_branch_prediction_bht_gshare dut (
    .clk                  (clk),
    .reset                (reset),
    .pc_jmp               (pc_jmp),
    .pc_prediction_take   (pc_prediction_take),
    .pc_prediction_strong (pc_prediction_strong),
    .pc_prediction_ghr    (pc_prediction_ghr),
    .pc_jmp_feedback      (pc_jmp_feedback),
    .pc_jmp_take          (pc_jmp_take),
    .pc_stash_base        (pc_stash_base),
    .pc_stash_ghr         (pc_stash_ghr),
    .pc_ghr_clear         (pc_ghr_clear)
  );

  always #5 clk = ~clk;

  // Word index of the PC, history XORed into the top 8 of 10 index bits.
  function automatic int model_idx(input logic [31:0] pc, input int g);
    int p;
    p = int'((pc >> 2) & 32'd1023);
    return p ^ ((g & 255) * 4);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: counters in 0..3, history as an 8-bit shift of outcomes.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_ctr[i] = 2;
      m_ghr = 0;
    end else begin
      if (pc_jmp_feedback) begin
        int k;
        k = model_idx(pc_stash_base, int'(pc_stash_ghr));
        if (pc_jmp_take) m_ctr[k] = (m_ctr[k] >= 3) ? 3 : m_ctr[k] + 1;
        else             m_ctr[k] = (m_ctr[k] <= 0) ? 0 : m_ctr[k] - 1;
      end
      if (pc_ghr_clear)         m_ghr = 0;
      else if (pc_jmp_feedback) m_ghr = ((m_ghr * 2) + int'(pc_jmp_take)) & 255;
    end
  end

  // Every cycle: outputs against the model for the current PC and state.
  always @(negedge clk) begin
    if (check_en) begin
      int c;
      c = m_ctr[model_idx(pc_jmp, m_ghr)];
      check("take",   int'(pc_prediction_take),   (c >= 2) ? 1 : 0);
      check("strong", int'(pc_prediction_strong), (c == 3 || c == 0) ? 1 : 0);
      check("ghr",    int'(pc_prediction_ghr),    m_ghr);
    end
  end

  task automatic drive(input logic [31:0] pc, input logic fb, input logic tk,
                       input logic [31:0] sb, input logic [7:0] sg, input logic clr);
    @(posedge clk);
    #2;
    pc_jmp = pc; pc_jmp_feedback = fb; pc_jmp_take = tk;
    pc_stash_base = sb; pc_stash_ghr = sg; pc_ghr_clear = clr;
  endtask

  initial begin
    logic [7:0] pat;
    reset = 1'b1;
    pc_jmp = '0; pc_jmp_feedback = 1'b0; pc_jmp_take = 1'b0;
    pc_stash_base = '0; pc_stash_ghr = '0; pc_ghr_clear = 1'b0;

    // Reset sweep with junk feedback that must be discarded.
    for (int i = 0; i < DEPTH; i++) begin
      drive(32'(i) << 2, 1'($urandom), 1'($urandom), $urandom, 8'($urandom), 1'b0);
      check_en = 1'b1;
      #2;
      check("rst_take",   int'(pc_prediction_take),   1);
      check("rst_strong", int'(pc_prediction_strong), 0);
      check("rst_ghr",    int'(pc_prediction_ghr),    0);
    end
    reset = 1'b0;

    // Saturation at 0x40 with history held at zero.
    repeat (3) drive(32'h40, 1'b1, 1'b1, 32'h40, 8'h00, 1'b1);
    drive(32'h40, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0); #2;
    check("sat_hi_take",   int'(pc_prediction_take),   1);
    check("sat_hi_strong", int'(pc_prediction_strong), 1);
    check("sat_hi_model",  m_ctr[16], 3);
    repeat (5) drive(32'h40, 1'b1, 1'b0, 32'h40, 8'h00, 1'b1);
    drive(32'h40, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0); #2;
    check("sat_lo_take",   int'(pc_prediction_take),   0);
    check("sat_lo_strong", int'(pc_prediction_strong), 1);
    check("sat_lo_model",  m_ctr[16], 0);

    // Hysteresis from strongly taken.
    repeat (3) drive(32'h40, 1'b1, 1'b1, 32'h40, 8'h00, 1'b1);
    drive(32'h40, 1'b1, 1'b0, 32'h40, 8'h00, 1'b1);
    drive(32'h40, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0); #2;
    check("hyst1_take",   int'(pc_prediction_take),   1);
    check("hyst1_strong", int'(pc_prediction_strong), 0);
    drive(32'h40, 1'b1, 1'b0, 32'h40, 8'h00, 1'b1);
    drive(32'h40, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0); #2;
    check("hyst2_take", int'(pc_prediction_take), 0);

    // Same-cycle lookup and update: no bypass.
    drive(32'h800, 1'b1, 1'b0, 32'h800, 8'h00, 1'b1); #2;
    check("haz_same_take", int'(pc_prediction_take), 1);
    drive(32'h800, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0); #2;
    check("haz_next_take", int'(pc_prediction_take), 0);
    check("haz_model",     m_ctr[32'h200], 1);

    // Gshare training uses the stashed history.
    drive(32'h100, 1'b1, 1'b1, 32'h100, 8'hA5, 1'b0);
    drive(32'h100, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0); #2;
    check("gs_ghr",    int'(pc_prediction_ghr),    1);
    check("gs_take",   int'(pc_prediction_take),   1);
    check("gs_strong", int'(pc_prediction_strong), 0);
    check("gs_model_trained", m_ctr[32'h2D4], 3);
    drive(32'hB40, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0); #2;
    check("gs_trained_strong", int'(pc_prediction_strong), 1);

    // Build history 0x5A, then clear together with taken feedback.
    drive(32'h0, 1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
    pat = 8'h5A;
    for (int k = 7; k >= 0; k--) drive(32'h0, 1'b1, pat[k], 32'hC00, 8'h00, 1'b0);
    drive(32'h1A0, 1'b1, 1'b1, 32'h400, 8'h5A, 1'b1); #2;
    check("clr_pre_ghr", int'(pc_prediction_ghr), 32'h5A);
    drive(32'h1A0, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0); #2;
    check("clr_ghr",    int'(pc_prediction_ghr),    0);
    check("clr_take",   int'(pc_prediction_take),   1);
    check("clr_strong", int'(pc_prediction_strong), 1);
    check("clr_model",  m_ctr[32'h68], 3);

    // Random traffic on a small set of hot entries plus random PCs and resets.
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] pc, sb;
      logic [7:0]  sg;
      pc = ($urandom_range(0, 3) == 0) ? $urandom : (($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2));
      sb = ($urandom_range(0, 1) == 0) ? pc : (32'($urandom_range(0, 15)) << 2);
      sg = ($urandom_range(0, 1) == 0) ? pc_prediction_ghr : 8'($urandom);
      drive(pc, 1'($urandom_range(0, 3) != 0), 1'($urandom), sb, sg,
            1'($urandom_range(0, 49) == 0));
      reset = ($urandom_range(0, 199) == 0);
    end
    drive(32'h0, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
